// File: rtl/movegen_sequencer.sv
// Sequences one pseudo-legal move-generation pass: replays a host position onto the
// board's serial bus, pulses start, then forwards and counts the returned move stream.
module movegen_sequencer #(
    parameter int SQUARES = 64,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wtp,
    input  logic [3:0]       req_castle,
    input  logic [2:0]       req_ep,
    input  logic             sq_valid,
    input  logic [3:0]       sq_data,
    output logic             sq_ready,
    output logic             pos_valid,
    output logic [3:0]       pos_data,
    output logic             pos_sop,
    output logic             pos_eop,
    output logic             wtp,
    output logic [3:0]       castle,
    output logic [2:0]       ep,
    output logic             start,
    input  logic             uci_valid,
    input  logic [19:0]      uci_data,
    input  logic             uci_eop,
    output logic             mv_valid,
    output logic [19:0]      mv_data,
    output logic             done,
    output logic [CNT_W-1:0] move_count,
    output logic             timeout_err
);

    localparam int SQ_W  = (SQUARES > 1) ? $clog2(SQUARES) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SQ_W-1:0]  LAST_SQ   = SQ_W'(SQUARES - 1);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_COLLECT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             w_req_acc;
    logic             w_sq_acc;
    logic             w_mv_acc;
    logic             w_eop_hit;
    logic             w_tmo_hit;

    logic             r_req_ready;
    logic             r_sq_ready;
    logic [SQ_W-1:0]  r_sq_cnt;
    logic             r_wtp;
    logic [3:0]       r_castle;
    logic [2:0]       r_ep;
    logic             r_pos_valid;
    logic [3:0]       r_pos_data;
    logic             r_pos_sop;
    logic             r_pos_eop;
    logic             r_start;
    logic [TMR_W-1:0] r_timer;
    logic             r_mv_valid;
    logic [19:0]      r_mv_data;
    logic             r_done;
    logic [CNT_W-1:0] r_move_count;
    logic             r_timeout_err;

    // An eop arriving on the last timer tick takes priority over the timeout.
    always_comb begin
        w_req_acc = (r_state == S_IDLE) && req_valid;
        w_sq_acc  = (r_state == S_LOAD) && sq_valid;
        w_mv_acc  = (r_state == S_COLLECT) && uci_valid;
        w_eop_hit = w_mv_acc && uci_eop;
        w_tmo_hit = (r_state == S_COLLECT) && (r_timer == LAST_TICK) && !w_eop_hit;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (req_valid) w_next = S_LOAD;
            S_LOAD:    if (sq_valid && (r_sq_cnt == LAST_SQ)) w_next = S_START;
            S_START:   w_next = S_COLLECT;
            S_COLLECT: if (w_eop_hit || w_tmo_hit) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_sq_ready  <= 1'b0;
            r_sq_cnt    <= '0;
            r_wtp       <= 1'b0;
            r_castle    <= '0;
            r_ep        <= '0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == S_IDLE);
            r_sq_ready  <= (w_next == S_LOAD);
            if (w_req_acc) begin
                r_sq_cnt <= '0;
                r_wtp    <= req_wtp;
                r_castle <= req_castle;
                r_ep     <= req_ep;
            end else if (w_sq_acc) begin
                r_sq_cnt <= r_sq_cnt + SQ_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos_valid <= 1'b0;
            r_pos_data  <= '0;
            r_pos_sop   <= 1'b0;
            r_pos_eop   <= 1'b0;
        end else begin
            r_pos_valid <= w_sq_acc;
            r_pos_sop   <= w_sq_acc && (r_sq_cnt == '0);
            r_pos_eop   <= w_sq_acc && (r_sq_cnt == LAST_SQ);
            if (w_sq_acc) r_pos_data <= sq_data;
        end
    end

    // Count and timeout flag survive DONE so the host can read them after the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start       <= 1'b0;
            r_timer       <= '0;
            r_mv_valid    <= 1'b0;
            r_mv_data     <= '0;
            r_done        <= 1'b0;
            r_move_count  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_start    <= (r_state == S_START);
            r_mv_valid <= w_mv_acc;
            r_done     <= (w_next == S_DONE);
            if (w_mv_acc) r_mv_data <= uci_data;
            if (r_state == S_START) begin
                r_timer      <= '0;
                r_move_count <= '0;
            end else if (r_state == S_COLLECT) begin
                r_timer <= r_timer + TMR_W'(1);
                if (uci_valid && (r_move_count != CNT_MAX))
                    r_move_count <= r_move_count + CNT_W'(1);
            end
            if (w_req_acc)      r_timeout_err <= 1'b0;
            else if (w_tmo_hit) r_timeout_err <= 1'b1;
        end
    end

    assign req_ready   = r_req_ready;
    assign sq_ready    = r_sq_ready;
    assign pos_valid   = r_pos_valid;
    assign pos_data    = r_pos_data;
    assign pos_sop     = r_pos_sop;
    assign pos_eop     = r_pos_eop;
    assign wtp         = r_wtp;
    assign castle      = r_castle;
    assign ep          = r_ep;
    assign start       = r_start;
    assign mv_valid    = r_mv_valid;
    assign mv_data     = r_mv_data;
    assign done        = r_done;
    assign move_count  = r_move_count;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/movegen_sequencer.md
Name:
movegen_sequencer

Overview:
- Controller that sequences one psudolegal move-generation pass on the board datapath.
- Accepts a position request from a host: side-to-move, castle rights, ep file, then 64 square nibbles.
- Replays the squares onto the board's serial in_pos bus with sop/eop framing, then pulses start.
- Forwards the UCI move stream back to the host, counts moves, signals completion, and times out if the board never sends eop.

Parameters:
- SQUARES, 64: squares per position; the last beat index is SQUARES-1.
- CNT_W, 8: move_count width; the count saturates at 2^CNT_W-1.
- TIMEOUT, 1024: maximum cycles in COLLECT before the pass is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  host requests a generation pass
- req_ready  out  1  high in IDLE only
- req_wtp  in  1  white to play; sampled on req handshake
- req_castle  in  4  KQkq rights; sampled on req handshake
- req_ep  in  3  en-passant file; sampled on req handshake
- sq_valid  in  1  host square beat valid
- sq_data  in  4  {colour, piece[2:0]}, in board serial order
- sq_ready  out  1  high in LOAD only
- pos_valid  out  1  board in_pos_valid
- pos_data  out  4  board in_pos_data
- pos_sop  out  1  first square beat
- pos_eop  out  1  last square beat
- wtp  out  1  board in_wtp
- castle  out  4  board in_castle
- ep  out  3  board in_ep
- start  out  1  one-cycle pulse to begin move emission
- uci_valid  in  1  board o_uci_valid
- uci_data  in  20  board o_uci_data
- uci_eop  in  1  board o_uci_eop
- mv_valid  out  1  forwarded move valid; no backpressure
- mv_data  out  20  forwarded move
- done  out  1  one-cycle completion pulse
- move_count  out  CNT_W  moves forwarded in the last pass
- timeout_err  out  1  last pass ended by timeout

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - Reset mid-pass abandons the pass; no done is emitted.
- Outputs are registered.
- wtp, castle and ep are loaded on the req handshake and held until the next handshake.
- IDLE:
  - req_ready=1.
  - On req_valid: latch the request fields, clear sq_cnt, clear timeout_err, go to LOAD.
- LOAD:
  - sq_ready=1.
  - Each accepted beat (sq_valid) drives the next cycle: pos_valid=1, pos_data=sq_data, pos_sop=(sq_cnt==0), pos_eop=(sq_cnt==SQUARES-1).
  - sq_cnt increments on each accepted beat.
  - Gaps (sq_valid=0) produce pos_valid=0; framing is preserved across gaps.
  - The accept of beat SQUARES-1 moves to START; sq_ready drops in the same cycle that pos_eop is output.
- START:
  - start=1 for exactly one cycle, in the cycle after pos_eop.
  - Clears move_count and the timer.
  - Next state is COLLECT.
- COLLECT:
  - Timer increments every cycle.
  - Each uci_valid produces mv_valid=1 and mv_data=uci_data one cycle later.
  - move_count increments per uci_valid and saturates at 2^CNT_W-1; mv forwarding continues past saturation.
  - uci_valid & uci_eop: forward that move, then go to DONE.
  - Timer reaching TIMEOUT-1 without eop: timeout_err=1, go to DONE.
  - If eop and timeout occur in the same cycle, eop wins and timeout_err stays 0.
- DONE:
  - done=1 for one cycle, then IDLE.
  - move_count and timeout_err hold until the next request is accepted.
- uci_valid outside COLLECT is ignored: no mv_valid, no count.
- sq_valid outside LOAD is ignored.
- uci_eop without uci_valid is ignored.
- req_valid while not IDLE has no effect.

Test Plan:
- Start position, wtp=1, castle=4'b1111, 64 contiguous beats:
  - pos_sop on the 1st pos beat and pos_eop on the 64th.
  - start is exactly 1 cycle, in the cycle after pos_eop.
  - With a board model returning 20 moves and eop on the 20th: move_count=20, done pulse, timeout_err=0.
- Host inserts a 1-cycle gap after every square:
  - 64 pos beats, with pos_valid low on the gap cycles.
  - sop and eop each asserted once; start timing is relative to pos_eop.
- Board model never asserts eop, TIMEOUT=1024:
  - done asserts 1024 cycles after start, with timeout_err=1.
  - The next req accept clears timeout_err.
- Board model emits 300 moves with CNT_W=8:
  - move_count=255.
  - mv_valid count equals 300.
- Assert rst during LOAD at beat 30:
  - All outputs return to 0, req_ready=1, no done pulse.
  - A new full request completes normally.
- Stray uci_valid while in IDLE and LOAD → no mv_valid and move_count unchanged. uci_eop coincident with the timeout cycle → timeout_err=0.
